hub_rr_scheduler: RTL and testbench
===================================

// Module: hub_rr_scheduler
// PURPOSE
//  Round-robin scheduler for the 4-port hub broadcast datapath.
//  - Buffers bytes arriving on each port in a per-port FIFO.
//  - Grants the shared broadcast slot to one port per cycle.
//  - Drives the granted byte to every port except its source.
//  - Sits between the hub's port receivers and the transmit drivers; it replaces ad-hoc fan-out when several ports send at once.
// PARAMETERS
//  DATA_W      8   byte width of din*/dout*
//  FIFO_DEPTH  4   entries per port FIFO (power of 2, >=2)
// PORTS
//  clk        in   1       single clock, all logic on rising edge
//  reset      in   1       synchronous, active-high; clears all state
//  din0..3    in   DATA_W  byte from port i, sampled when inv_i=1
//  inv0..3    in   1       port i input valid, one byte per cycle
//  dout0..3   out  DATA_W  broadcast byte to port i (registered)
//  outv0..3   out  1       dout_i valid this cycle (registered)
//  drop0..3   out  1       1-cycle pulse: byte on port i discarded (FIFO full)
//  gnt_v      out  1       a byte was broadcast this cycle (registered)
//  gnt_id     out  2       source port of the current broadcast
// BEHAVIOUR
//  Reset: FIFOs empty, rr_ptr=0, all dout*=0, outv*=0, drop*=0, gnt_v=0, gnt_id=0.
//  Push: on edge with inv_i=1:
//   - if FIFO_i not full, or FIFO_i is popped on the same edge: byte enqueued.
//   - else byte discarded and drop_i=1 for the next cycle.
//  Arbitrate (each edge):
//   - Winner w = first non-empty FIFO scanning rr_ptr, rr_ptr+1, .. (mod 4).
//   - Occupancy is taken before this edge's push, so there is no bypass.
//   - Pop FIFO_w.
//   - Register dout_j=head_w and outv_j=1 for all j!=w.
//   - Register dout_w=0 and outv_w=0; gnt_v=1, gnt_id=w.
//   - Set rr_ptr=w+1 mod 4 (wraps 3->0).
//  Idle: no FIFO non-empty -> all outv*=0, dout*=0, gnt_v=0, gnt_id and rr_ptr hold.
//  Latency: byte pushed at edge k is broadcast at the earliest after edge k+1.
//   - The 1-cycle minimum holds when its FIFO is empty and it wins.
//   - Worst case behind other ports: 4*FIFO_DEPTH cycles.
//  Order: bytes from one port leave in arrival order.
//   - No byte is duplicated or reordered.
//   - Bytes are lost only when flagged by drop_i.
//  Fairness: a continuously backlogged port is granted at least once every 4 cycles.
//  Width: FIFO count is log2(FIFO_DEPTH)+1 bits; pointers wrap mod FIFO_DEPTH.
//  Reset mid-operation: all buffered bytes are discarded silently.
//   - No drop pulse is raised for them.
//   - Outputs read 0 in the cycle after the reset edge.
// STRUCTURE
//  Shared package hub_pkg: HUB_PORTS=4, HUB_DATA_W=8, port-id type (2 bits).
//  One sub-module, hub_port_fifo (sync FIFO: push, pop, full, empty, head); instantiated 4x.
//  Arbiter, rr_ptr and output registers are in this module; combinational priority scan.
// TESTING
//  1. After reset: din0=112/inv0=1 and din2=200/inv2=1 for one cycle.
//     -> cycle+1: outv=4'b1110, dout1..3=112, gnt_id=0.
//     -> cycle+2: outv=4'b1011, dout0/1/3=200, gnt_id=2.
//     -> then idle, outv=0.
//  2. All four ports push 1 byte simultaneously (0x10,0x11,0x12,0x13), rr_ptr=0.
//     -> gnt_id sequence 0,1,2,3 on consecutive cycles.
//     -> each byte is absent only at its source port.
//  3. Port 1 pushes 6 bytes back-to-back (0xA0..0xA5) while port 0 streams continuously (DEPTH=4).
//     -> grants alternate 0,1.
//     -> drop1 pulses for exactly the overflowing bytes.
//     -> surviving port-1 bytes are output in order.
//  4. FIFO_3 full; push and pop on port 3 in the same edge.
//     -> no drop3, count stays 4, new byte is broadcast later.
//  5. Reset asserted with 3 bytes queued on port 2.
//     -> next cycle outv=0, drop=0.
//     -> after release, no stale byte appears and rr_ptr restarts at 0.
//  6. Only port 3 active for 5 cycles.
//     -> gnt_id=3 every cycle, rr_ptr wraps to 0, outv3 always 0.

Source files
------------

// File: rtl/hub_pkg.sv
// Shared hub constants and the port-id type used by the broadcast scheduler.
package hub_pkg;

  localparam int HUB_PORTS  = 4;
  localparam int HUB_DATA_W = 8;

  typedef logic [1:0] port_id_t;

  // Next port in round-robin order; the 2-bit width gives the 3->0 wrap for free.
  function automatic port_id_t port_next(input port_id_t p);
    return p + 2'd1;
  endfunction

endpackage

// File: rtl/hub_port_fifo.sv
// Per-port sync FIFO: zero-latency head, one write and one read per cycle.
// Caller gates push against full (a same-edge pop frees the slot); pop is only issued when non-empty.
module hub_port_fifo
  import hub_pkg::*;
#(
  parameter int DATA_W = HUB_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_dat,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/hub_rr_scheduler.sv
// Round-robin broadcast of one buffered byte per cycle to all ports but its source; >=1 cycle push-to-output.
// No backpressure upstream: a byte hitting a full FIFO that is not popped that edge is discarded and flagged on drop_i.
module hub_rr_scheduler
  import hub_pkg::*;
#(
  parameter int DATA_W     = HUB_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  input  logic [DATA_W-1:0] din2,
  input  logic [DATA_W-1:0] din3,
  input  logic              inv0,
  input  logic              inv1,
  input  logic              inv2,
  input  logic              inv3,
  output logic [DATA_W-1:0] dout0,
  output logic [DATA_W-1:0] dout1,
  output logic [DATA_W-1:0] dout2,
  output logic [DATA_W-1:0] dout3,
  output logic              outv0,
  output logic              outv1,
  output logic              outv2,
  output logic              outv3,
  output logic              drop0,
  output logic              drop1,
  output logic              drop2,
  output logic              drop3,
  output logic              gnt_v,
  output logic [1:0]        gnt_id
);

  logic [DATA_W-1:0]    din_vec  [HUB_PORTS];
  logic [DATA_W-1:0]    head_vec [HUB_PORTS];
  logic [HUB_PORTS-1:0] inv_vec;
  logic [HUB_PORTS-1:0] full_vec;
  logic [HUB_PORTS-1:0] empty_vec;
  logic [HUB_PORTS-1:0] pop_vec;
  logic [HUB_PORTS-1:0] push_ok;

  logic     win_vld;
  port_id_t win_id;
  port_id_t scan_id;

  logic [DATA_W-1:0]    dout_q [HUB_PORTS];
  logic [DATA_W-1:0]    dout_d [HUB_PORTS];
  logic [HUB_PORTS-1:0] outv_q, outv_d;
  logic [HUB_PORTS-1:0] drop_q, drop_d;
  logic                 gnt_v_q, gnt_v_d;
  port_id_t             gnt_id_q, gnt_id_d;
  port_id_t             rr_ptr_q, rr_ptr_d;

  assign din_vec[0] = din0;
  assign din_vec[1] = din1;
  assign din_vec[2] = din2;
  assign din_vec[3] = din3;
  assign inv_vec    = {inv3, inv2, inv1, inv0};

  for (genvar i = 0; i < HUB_PORTS; i++) begin : g_fifo
    hub_port_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push_ok[i]),
      .pop      (pop_vec[i]),
      .push_dat (din_vec[i]),
      .full     (full_vec[i]),
      .empty    (empty_vec[i]),
      .head     (head_vec[i])
    );
  end

  // Scan farthest-first so the port nearest rr_ptr overwrites and wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = rr_ptr_q;
    scan_id = '0;
    for (int k = HUB_PORTS - 1; k >= 0; k--) begin
      scan_id = rr_ptr_q + port_id_t'(k);
      if (!empty_vec[scan_id]) begin
        win_vld = 1'b1;
        win_id  = scan_id;
      end
    end
  end

  always_comb begin
    pop_vec = '0;
    if (win_vld) begin
      pop_vec[win_id] = 1'b1;
    end
    push_ok = inv_vec & (~full_vec | pop_vec);
    drop_d  = inv_vec & full_vec & ~pop_vec;
    for (int j = 0; j < HUB_PORTS; j++) begin
      outv_d[j] = win_vld && (win_id != port_id_t'(j));
      dout_d[j] = outv_d[j] ? head_vec[win_id] : '0;
    end
    gnt_v_d  = win_vld;
    gnt_id_d = win_vld ? win_id : gnt_id_q;
    rr_ptr_d = win_vld ? port_next(win_id) : rr_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < HUB_PORTS; j++) begin
        dout_q[j] <= '0;
      end
      outv_q   <= '0;
      drop_q   <= '0;
      gnt_v_q  <= 1'b0;
      gnt_id_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      dout_q   <= dout_d;
      outv_q   <= outv_d;
      drop_q   <= drop_d;
      gnt_v_q  <= gnt_v_d;
      gnt_id_q <= gnt_id_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign dout0  = dout_q[0];
  assign dout1  = dout_q[1];
  assign dout2  = dout_q[2];
  assign dout3  = dout_q[3];
  assign outv0  = outv_q[0];
  assign outv1  = outv_q[1];
  assign outv2  = outv_q[2];
  assign outv3  = outv_q[3];
  assign drop0  = drop_q[0];
  assign drop1  = drop_q[1];
  assign drop2  = drop_q[2];
  assign drop3  = drop_q[3];
  assign gnt_v  = gnt_v_q;
  assign gnt_id = gnt_id_q;

endmodule

// File: tb/tb_hub_rr_scheduler.sv
// Directed bench for hub_rr_scheduler: hand-derived grant order, broadcast data, drop pulses and reset behaviour.
module tb_hub_rr_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din0, din1, din2, din3;
  logic       inv0, inv1, inv2, inv3;
  logic [7:0] dout0, dout1, dout2, dout3;
  logic       outv0, outv1, outv2, outv3;
  logic       drop0, drop1, drop2, drop3;
  logic       gnt_v;
  logic [1:0] gnt_id;

  int nerr = 0;
  int nchk = 0;

  hub_rr_scheduler #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .din0   (din0),
    .din1   (din1),
    .din2   (din2),
    .din3   (din3),
    .inv0   (inv0),
    .inv1   (inv1),
    .inv2   (inv2),
    .inv3   (inv3),
    .dout0  (dout0),
    .dout1  (dout1),
    .dout2  (dout2),
    .dout3  (dout3),
    .outv0  (outv0),
    .outv1  (outv1),
    .outv2  (outv2),
    .outv3  (outv3),
    .drop0  (drop0),
    .drop1  (drop1),
    .drop2  (drop2),
    .drop3  (drop3),
    .gnt_v  (gnt_v),
    .gnt_id (gnt_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] d3);
    {inv3, inv2, inv1, inv0} = v;
    din0 = d0;
    din1 = d1;
    din2 = d2;
    din3 = d3;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input int src, input logic [7:0] d);
    logic [3:0]  ev;
    logic [31:0] ed;
    ev = 4'hF;
    ev[src] = 1'b0;
    ed = {d, d, d, d};
    ed[src*8 +: 8] = 8'h00;
    chk({tag, "_outv"}, {28'd0, outv3, outv2, outv1, outv0}, {28'd0, ev});
    chk({tag, "_dout"}, {dout3, dout2, dout1, dout0}, ed);
    chk({tag, "_gntv"}, {31'd0, gnt_v}, 32'd1);
    chk({tag, "_gntid"}, {30'd0, gnt_id}, src);
  endtask

  task automatic chk_idle(input string tag, input int id);
    chk({tag, "_outv"}, {28'd0, outv3, outv2, outv1, outv0}, 32'd0);
    chk({tag, "_dout"}, {dout3, dout2, dout1, dout0}, 32'd0);
    chk({tag, "_gntv"}, {31'd0, gnt_v}, 32'd0);
    chk({tag, "_gntid"}, {30'd0, gnt_id}, id);
  endtask

  task automatic chk_drop(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, drop3, drop2, drop1, drop0}, {28'd0, exp});
  endtask

  task automatic do_reset();
    drive(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int src;
    logic [7:0] d;

    reset = 1'b1;
    drive(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    tick();
    chk_idle("rst", 0);
    chk_drop("rst_drop", 4'h0);
    reset = 1'b0;

    // Two ports at once: port 0 wins first, then port 2; nothing visible the push cycle.
    drive(4'b0101, 8'd112, 8'h00, 8'd200, 8'h00);
    tick();
    drive(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    chk_idle("t1_nobypass", 0);
    tick();
    chk_b("t1_g0", 0, 8'd112);
    tick();
    chk_b("t1_g2", 2, 8'd200);
    tick();
    chk_idle("t1_idle", 2);

    // All four ports push once: grants 0,1,2,3.
    do_reset();
    drive(4'hF, 8'h10, 8'h11, 8'h12, 8'h13);
    tick();
    drive(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int s = 0; s < 4; s++) begin
      tick();
      chk_b($sformatf("t2_g%0d", s), s, 8'h10 + 8'(s));
    end
    tick();
    chk_idle("t2_idle", 3);

    // Port 0 streams while port 1 sends A0..A5: strict 0/1 alternation, FIFO1 peaks at 4, no drop.
    do_reset();
    for (int e = 1; e <= 13; e++) begin
      if (e <= 6) drive(4'b0011, 8'h01 + 8'(e - 1), 8'hA0 + 8'(e - 1), 8'h00, 8'h00);
      else        drive(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
      tick();
      if (e >= 2) begin
        src = (e - 2) % 2;
        d = (src == 1) ? 8'hA0 + 8'((e - 2) / 2) : 8'h01 + 8'((e - 2) / 2);
        chk_b($sformatf("t3_e%0d", e), src, d);
      end
      chk_drop($sformatf("t3_drop_e%0d", e), 4'h0);
    end
    tick();
    chk_idle("t3_idle", 1);

    // All ports push six cycles: port 3 full+popped at edge 5 (kept), edge 6 drops on 1,2,3.
    do_reset();
    for (int e = 1; e <= 6; e++) begin
      drive(4'hF, 8'h00 + 8'(e), 8'h10 + 8'(e), 8'h20 + 8'(e), 8'h30 + 8'(e));
      tick();
      if (e == 2) chk_b("t4_e2", 0, 8'h01);
      if (e == 3) chk_b("t4_e3", 1, 8'h11);
      if (e == 4) chk_b("t4_e4", 2, 8'h21);
      if (e == 5) begin
        chk_b("t4_e5", 3, 8'h31);
        chk_drop("t4_samepop_nodrop", 4'h0);
      end
      if (e == 6) begin
        chk_b("t4_e6", 0, 8'h02);
        chk_drop("t4_overflow", 4'b1110);
      end
    end
    drive(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int s = 0; s < 16; s++) begin
      tick();
      src = (s + 1) % 4;
      d = (src == 0) ? 8'h03 + 8'(s / 4) : 8'(src * 16 + 2 + s / 4);
      chk_b($sformatf("t4_drain%0d", s), src, d);
      if (s == 0) chk_drop("t4_drop_pulse_end", 4'h0);
    end
    tick();
    chk_idle("t4_idle", 0);

    // Reset with three bytes queued on port 2; rr_ptr was 2, so a stale pointer would pick port 3 first.
    do_reset();
    for (int e = 1; e <= 3; e++) begin
      drive(4'hF, 8'h00 + 8'(e), 8'h10 + 8'(e), 8'h20 + 8'(e), 8'h30 + 8'(e));
      tick();
    end
    drive(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    reset = 1'b1;
    tick();
    chk_idle("t5_inrst", 0);
    chk_drop("t5_inrst_drop", 4'h0);
    reset = 1'b0;
    tick();
    tick();
    chk_idle("t5_nostale", 0);
    drive(4'b1001, 8'h55, 8'h00, 8'h00, 8'h66);
    tick();
    drive(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    chk_b("t5_rr0", 0, 8'h55);
    tick();
    chk_b("t5_then3", 3, 8'h66);

    // Only port 3 active: granted every cycle, pointer wraps to 0 each time.
    do_reset();
    for (int e = 1; e <= 5; e++) begin
      drive(4'b1000, 8'h00, 8'h00, 8'h00, 8'h30 + 8'(e));
      tick();
      if (e >= 2) chk_b($sformatf("t6_e%0d", e), 3, 8'h30 + 8'(e - 1));
    end
    drive(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    chk_b("t6_e6", 3, 8'h35);
    tick();
    chk_idle("t6_idle", 3);
    drive(4'b0101, 8'h77, 8'h00, 8'h88, 8'h00);
    tick();
    drive(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    chk_b("t6_wrap0", 0, 8'h77);
    tick();
    chk_b("t6_wrap2", 2, 8'h88);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
